// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide engine for the execute stage. Handles
//            MULT, MULTU, DIV and DIVU on WIDTH-bit operands and returns a
//            {hi, lo} pair for the HI/LO register. Multiplication is radix-2
//            shift-add; division is restoring. Both work on magnitudes, and
//            the sign is fixed up on the way into DONE.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous reset, active low
//            start_i  - start request, accepted in IDLE or DONE
//            op_i     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            a_i/b_i  - multiplicand/dividend, multiplier/divisor
//            annul_i  - cancel the in-flight operation
//            busy_o   - iterating (MUL or DIV state)
//            stall_o  - stall request to the hazard unit
//            ready_o  - one-cycle result-valid pulse
//            hi_o     - product upper half / remainder
//            lo_o     - product lower half / quotient
//            dbz_o    - divide by zero, held until the next accepted start
// Options  : MULDIV_FAST_MUL_EN - single-cycle combinational multiply
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] c_lastCnt = CNTW'(WIDTH - 1);

  state_t r_state;
  state_t w_nextState;

  logic [2*WIDTH-1:0] r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic [CNTW-1:0]    r_cnt;
  logic               r_negRes;  // product/quotient must be negated
  logic               r_negRem;  // remainder must be negated
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dbz;

  // Operand capture
  logic             w_idleOrDone;
  logic             w_accept;
  logic             w_signed;
  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic             w_dbzStart;
  logic             w_lastIter;

  assign w_idleOrDone = (r_state == S_IDLE) || (r_state == S_DONE);
  // annul_i beats start_i even when nothing is in flight
  assign w_accept     = w_idleOrDone && start_i && !annul_i;
  assign w_signed     = !op_i[0];
  assign w_aNeg       = w_signed && a_i[WIDTH-1];
  assign w_bNeg       = w_signed && b_i[WIDTH-1];
  assign w_aMag       = w_aNeg ? -a_i : a_i;
  assign w_bMag       = w_bNeg ? -b_i : b_i;
  assign w_dbzStart   = w_accept && op_i[1] && (b_i == '0);
  assign w_lastIter   = (r_cnt == c_lastCnt);

  // Shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH-1:0]   w_mulAdd;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [2*WIDTH-1:0] w_mulFinal;
  logic               w_mulDone;

  assign w_mulAdd  = r_acc[0] ? r_opnd : '0;
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mulAdd};
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fastProd;
  assign w_fastProd = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_opnd};
  assign w_mulFinal = w_fastProd;
  assign w_mulDone  = 1'b1;
`else
  assign w_mulFinal = w_mulNext;
  assign w_mulDone  = w_lastIter;
`endif

  // Restoring divide step: shift the next dividend bit into the remainder,
  // keep the difference only when it does not go negative.
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH:0]     w_divDiff;
  logic               w_divFits;
  logic [2*WIDTH-1:0] w_divNext;
  logic [WIDTH-1:0]   w_divQuo;
  logic [WIDTH-1:0]   w_divRem;

  assign w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_divDiff  = w_divShift - {1'b0, r_opnd};
  assign w_divFits  = !w_divDiff[WIDTH];
  assign w_divNext  = {(w_divFits ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_divFits};
  assign w_divQuo   = w_divNext[WIDTH-1:0];
  assign w_divRem   = w_divNext[2*WIDTH-1:WIDTH];

  // Sign-corrected results, captured on the edge that enters DONE
  logic [2*WIDTH-1:0] w_mulRes;
  logic [WIDTH-1:0]   w_quoRes;
  logic [WIDTH-1:0]   w_remRes;

  assign w_mulRes = r_negRes ? -w_mulFinal : w_mulFinal;
  assign w_quoRes = r_negRes ? -w_divQuo   : w_divQuo;
  assign w_remRes = r_negRem ? -w_divRem   : w_divRem;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and control outputs
  always_comb begin
    w_nextState = r_state;
    busy_o      = 1'b0;
    ready_o     = 1'b0;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) begin
          ready_o     = 1'b1;
          w_nextState = S_IDLE;
        end
        if (w_accept) begin
          if (w_dbzStart) begin
            w_nextState = S_DONE;
          end else if (op_i[1]) begin
            w_nextState = S_DIV;
          end else begin
            w_nextState = S_MUL;
          end
        end
      end
      S_MUL: begin
        busy_o = 1'b1;
        if (annul_i) begin
          w_nextState = S_IDLE;
        end else if (w_mulDone) begin
          w_nextState = S_DONE;
        end
      end
      S_DIV: begin
        busy_o = 1'b1;
        if (annul_i) begin
          w_nextState = S_IDLE;
        end else if (w_lastIter) begin
          w_nextState = S_DONE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
    // Low in DONE so the pipeline advances and captures the result
    stall_o = (start_i && (r_state == S_IDLE)) || busy_o;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_negRes <= w_aNeg ^ w_bNeg;
      r_negRem <= w_aNeg;
      r_dbz    <= w_dbzStart;
      if (op_i[1]) begin
        r_acc  <= {{WIDTH{1'b0}}, w_aMag};
        r_opnd <= w_bMag;
      end else begin
        r_acc  <= {{WIDTH{1'b0}}, w_bMag};
        r_opnd <= w_aMag;
      end
      // Divide by zero returns the raw dividend and an all-ones quotient
      if (w_dbzStart) begin
        r_hi <= a_i;
        r_lo <= '1;
      end
    end else if ((r_state == S_MUL) && !annul_i) begin
      r_acc <= w_mulNext;
      r_cnt <= r_cnt + CNTW'(1);
      if (w_mulDone) begin
        {r_hi, r_lo} <= w_mulRes;
      end
    end else if ((r_state == S_DIV) && !annul_i) begin
      r_acc <= w_divNext;
      r_cnt <= r_cnt + CNTW'(1);
      if (w_lastIter) begin
        r_hi <= w_remRes;
        r_lo <= w_quoRes;
      end
    end
  end

  assign hi_o  = r_hi;
  assign lo_o  = r_lo;
  assign dbz_o = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: fixed vectors, randomized
//            operations against an arithmetic reference, and hand-written
//            back-to-back, annul, stray-start and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         startI;
  logic [1:0]   opI;
  logic [W-1:0] aI;
  logic [W-1:0] bI;
  logic         annulI;
  logic         busyO;
  logic         stallO;
  logic         readyO;
  logic [W-1:0] hiO;
  logic [W-1:0] loO;
  logic         dbzO;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(startI),
    .op_i   (opI),
    .a_i    (aI),
    .b_i    (bI),
    .annul_i(annulI),
    .busy_o (busyO),
    .stall_o(stallO),
    .ready_o(readyO),
    .hi_o   (hiO),
    .lo_o   (loO),
    .dbz_o  (dbzO)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: returns {dbz, hi, lo}
  function automatic logic [64:0] refModel(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0]     res;
    logic            dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    dz = 1'b0;
    res = '0;
    case (op)
      2'b00: begin
        q   = sa * sb;
        res = q;
      end
      2'b01: begin
        up  = ua * ub;
        res = up;
      end
      2'b10: begin
        if (b == 0) begin
          dz  = 1'b1;
          res = {a, 32'hFFFF_FFFF};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) begin
          dz  = 1'b1;
          res = {a, 32'hFFFF_FFFF};
        end else begin
          uq  = ua / ub;
          ur  = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return {dz, res};
  endfunction

  function automatic int refLat(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_LAT;
    if (b == 0) return 1;
    return DIV_LAT;
  endfunction

  function automatic logic [31:0] pick();
    int unsigned r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Starts an operation from IDLE, waits for ready_o. Returns with time at
  // the falling edge of the ready cycle (or lat = -1 on timeout).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic stallOk);
    opI = op; aI = a; bI = b; startI = 1'b1;
    lat = -1;
    stallOk = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c > 0 && readyO) begin
        lat = c;
        if (stallO) stallOk = 1'b0;
        break;
      end
      if (!stallO) stallOk = 1'b0;
      @(posedge clk); #1;
      startI = 1'b0;
    end
  endtask

  // Waits for ready_o starting in cycle c0 (time just after a rising edge).
  task automatic waitReady(input int c0, output int lat);
    lat = -1;
    for (int c = c0; c < c0 + 100; c++) begin
      @(negedge clk);
      if (readyO) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic runVec(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                        input logic expDbz, input int expLat);
    int   lat;
    logic sOk;
    issue(op, a, b, lat, sOk);
    check({name, " lat"}, 64'(lat), 64'(expLat));
    check({name, " hi"}, 64'(hiO), 64'(expHi));
    check({name, " lo"}, 64'(loO), 64'(expLo));
    check({name, " dbz"}, 64'(dbzO), 64'(expDbz));
    check({name, " stall"}, 64'(sOk), 64'(1'b1));
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    int          readies;
    logic [64:0] exp;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, DIV_LAT};
    vecs[5]  = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 1};
    vecs[6]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, DIV_LAT};
    vecs[7]  = '{2'b01, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0, MUL_LAT};
    vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, DIV_LAT};
    vecs[9]  = '{2'b00, 32'd0,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0, MUL_LAT};
    vecs[10] = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};

    rst = 1'b0; startI = 1'b0; opI = 2'b00; aI = '0; bI = '0; annulI = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {busyO, readyO, stallO, dbzO, hiO, loO}, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      runVec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
    end

    // dbz_o holds through idle cycles, then clears on the next accepted start
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dbz hold", {dbzO, readyO}, 2'b10);
    @(posedge clk); #1;
    opI = 2'b11; aI = 32'd100; bI = 32'd7; startI = 1'b1;
    @(posedge clk); #1;
    startI = 1'b0;
    @(negedge clk);
    check("dbz clear", 64'(dbzO), 64'(1'b0));
    @(posedge clk); #1;
    waitReady(2, lat);
    check("post dbz lo", 64'(loO), 64'd14);
    @(posedge clk); #1;

    // Back-to-back: DIVU launched in the DONE cycle of MULTU
    begin
      logic sOk;
      issue(2'b01, 32'd3, 32'd5, lat, sOk);
      check("b2b mul lat", 64'(lat), 64'(MUL_LAT));
      check("b2b mul lo", 64'(loO), 64'd15);
      opI = 2'b11; aI = 32'd9; bI = 32'd2; startI = 1'b1;
      @(posedge clk); #1;
      startI = 1'b0;
      waitReady(1, lat);
      check("b2b div lat", 64'(lat), 64'(DIV_LAT));
      check("b2b div hi/lo", {hiO, loO}, {32'd1, 32'd4});
      @(posedge clk); #1;
    end

    // Annul at cycle 10 of DIVU 100/7: no ready, result registers untouched
    opI = 2'b11; aI = 32'd100; bI = 32'd7; startI = 1'b1;
    @(posedge clk); #1;
    startI = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annulI = 1'b1;
    @(negedge clk);
    check("annul busy before", 64'(busyO), 64'(1'b1));
    @(posedge clk); #1;
    annulI = 1'b0;
    @(negedge clk);
    check("annul busy after", 64'(busyO), 64'(1'b0));
    readies = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (readyO) readies++;
    end
    check("annul no ready", 64'(readies), 64'd0);
    check("annul keeps hi/lo", {hiO, loO}, {32'd1, 32'd4});
    @(posedge clk); #1;

    // annul_i beats start_i in IDLE
    opI = 2'b01; aI = 32'd2; bI = 32'd2; startI = 1'b1; annulI = 1'b1;
    @(posedge clk); #1;
    startI = 1'b0; annulI = 1'b0;
    @(negedge clk);
    check("annul over start", {busyO, readyO}, 2'b00);
    @(posedge clk); #1;

    // A start seen while iterating is ignored
    opI = 2'b11; aI = 32'd100; bI = 32'd7; startI = 1'b1;
    @(posedge clk); #1;
    startI = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    opI = 2'b01; aI = 32'd2; bI = 32'd2; startI = 1'b1;
    @(posedge clk); #1;
    startI = 1'b0;
    waitReady(6, lat);
    check("stray start lat", 64'(lat), 64'(DIV_LAT));
    check("stray start hi/lo", {hiO, loO}, {32'd2, 32'd14});
    @(posedge clk); #1;

    // Asynchronous reset in cycle 5 of a MULT clears everything at once
    opI = 2'b00; aI = 32'd7; bI = 32'd9; startI = 1'b1;
    @(posedge clk); #1;
    startI = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async reset", {busyO, readyO, stallO, dbzO, hiO, loO}, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    runVec("after reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, MUL_LAT);

    // Randomized operations against the reference
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      exp = refModel(rop, ra, rb);
      runVec($sformatf("rand%0d op%0d %h,%h", i, rop, ra, rb), rop, ra, rb,
             exp[63:32], exp[31:0], exp[64], refLat(rop, rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the execute stage, generalising the fixed 32-bit divider into one WIDTH-configurable engine for MULT, MULTU, DIV and DIVU. Takes operands after forwarding and returns a {hi, lo} result pair that the pipeline carries to the HI/LO register. Drives a stall request to the hazard unit while iterating. Supports cancellation and reports divide-by-zero.

Parameters:
WIDTH, 32, operand width; hi_o and lo_o are each WIDTH bits.
CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
start_i  input  1  request a new operation; accepted only in IDLE or DONE
op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
a_i  input  WIDTH  multiplicand / dividend; sampled with start_i
b_i  input  WIDTH  multiplier / divisor; sampled with start_i
annul_i  input  1  cancel the in-flight operation
busy_o  output  1  high in MUL or DIV state
stall_o  output  1  stall request to hazard unit: (start_i & state==IDLE) | busy_o
ready_o  output  1  one-cycle pulse; hi_o/lo_o valid in that cycle
hi_o  output  WIDTH  MUL: upper product half; DIV: remainder
lo_o  output  WIDTH  MUL: lower product half; DIV: quotient
dbz_o  output  1  set with ready_o when a DIV/DIVU had b_i == 0; held until next accepted start

Behaviour:
- Reset (rst=0, any time, including mid-operation): state=IDLE; busy_o, ready_o, dbz_o = 0; hi_o, lo_o = 0; counter = 0. No partial result is emitted.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE/DONE + start_i: latch op_i, |a_i|, |b_i| (signed ops) or raw values (unsigned), and the result sign bits; counter=0; go to MUL (op_i[1]=0) or DIV (op_i[1]=1).
- start_i seen while in MUL or DIV: ignored.
- MUL: radix-2 shift-add on magnitudes, one bit per cycle, WIDTH cycles, into a 2*WIDTH accumulator, then DONE.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, WIDTH cycles, then DONE.
- DIV with b == 0: skip iteration and go to DONE on the next edge; lo_o = all ones, hi_o = a_i (raw), dbz_o = 1.
- DONE (exactly 1 cycle): apply sign correction and drive ready_o = 1.
  - Product is negated if sign(a) xor sign(b).
  - Quotient is negated if sign(a) xor sign(b).
  - Remainder takes the sign of the dividend.
  - Without a new start the FSM returns to IDLE; hi_o/lo_o hold until the next DONE.
- Latency: start accepted at edge 0 gives ready_o high in cycle WIDTH+1 (33 cycles for WIDTH=32). Divide-by-zero gives ready_o in cycle 1.
- Back-to-back: start_i in DONE is accepted; ready_o still pulses in that cycle and the new operation begins on the next edge.
- annul_i in MUL/DIV: go to IDLE on the next edge; no ready_o; hi_o/lo_o/dbz_o unchanged.
- annul_i in IDLE/DONE: no effect; annul_i takes priority over start_i in the same cycle.
- Overflow cases (two's complement wrap, no trap):
  - DIV of the most negative value by -1 gives lo_o = 0x8000_0000, hi_o = 0.
  - MULT of 0x8000_0000 by 0x8000_0000 gives {hi_o, lo_o} = 0x4000_0000_0000_0000.
- stall_o is combinational. It is low in DONE so the pipeline advances and captures the result.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: MULT/MULTU use a single-cycle combinational WIDTH x WIDTH multiply. The MUL state lasts one cycle, so ready_o is high in cycle 2 after start. DIV timing is unchanged.
- Undefined: iterative MUL as above, WIDTH cycles.

Test Plan:
MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> ready_o in cycle 33; hi_o=0xFFFF_FFFE, lo_o=0x0000_0001; stall_o high in cycles 0-32, low in cycle 33.
MULT a=0xFFFF_FFFD (-3), b=7 -> hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFEB (-21); MULT 0x8000_0000 x 0x8000_0000 -> hi_o=0x4000_0000, lo_o=0.
DIV a=-7 (0xFFFF_FFF9), b=2 -> lo_o=0xFFFF_FFFD (-3), hi_o=0xFFFF_FFFF (-1); DIV 0x8000_0000 by -1 -> lo_o=0x8000_0000, hi_o=0.
DIVU a=100, b=0 -> ready_o in cycle 1; dbz_o=1, lo_o=0xFFFF_FFFF, hi_o=100; next DIVU 100/7 -> dbz_o=0, lo_o=14, hi_o=2.
DIVU 100/7 then annul_i at cycle 10 -> FSM to IDLE, no ready_o, hi_o/lo_o keep previous values; rst=0 pulsed at cycle 5 of a new MULT -> all outputs 0 immediately.
Back-to-back: start MULTU 3x5 and, in its DONE cycle, start DIVU 9/2 -> ready_o pulses for lo_o=15, then 33 cycles later for lo_o=4, hi_o=1; with MULDIV_FAST_MUL_EN, 3x5 gives ready_o in cycle 2.
